// File: rtl/ad9708_dac_driver.sv
// ad9708_dac_driver: paced dual-channel DAC output driver with underflow accounting
// Ports:
//   da_clk, sys_rst_n           DAC-domain clock, async active-low reset
//   enable, rate_div            run/stop level; sample period minus 1 (latched on start)
//   s_valid/s_ready/s_data_A/B  sample-pair handshake from the waveform buffer
//   dac_clkA/B, dac_data_A/B    forwarded clocks (inverted da_clk) and DAC codes
//   underflow_cnt, busy         saturating missed-strobe count; driver not idle
// Build option: DAC_INVERT_EN maps each code to (HALF - sample), HALF = 2^(DATA_W-1).
module ad9708_dac_driver #(
   parameter int DATA_W = 12,
   parameter int DIV_W = 16,
   parameter logic [DATA_W-1:0] MIDSCALE = 12'd2048
) (
   input  logic              da_clk,
   input  logic              sys_rst_n,
   input  logic              enable,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data_A,
   input  logic [DATA_W-1:0] s_data_B,
   output logic              dac_clkA,
   output logic              dac_clkB,
   output logic [DATA_W-1:0] dac_data_A,
   output logic [DATA_W-1:0] dac_data_B,
   output logic [DIV_W-1:0]  underflow_cnt,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;
   state_t state, state_nx;
   logic [DIV_W-1:0] rate_l, div_cnt;
   logic [DATA_W-1:0] hold_A, hold_B;
   logic hold_v, strobe, xfer;
`ifdef DAC_INVERT_EN
   localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};
   // self-inverse mapping shared with the capture path
   function automatic logic [DATA_W-1:0] map_code(input logic [DATA_W-1:0] x);
      return HALF - x;
   endfunction
`else
   function automatic logic [DATA_W-1:0] map_code(input logic [DATA_W-1:0] x);
      return x;
   endfunction
`endif
   // DAC latches on the falling da_clk edge, mid-way through the launched data
   assign dac_clkA = ~da_clk;
   assign dac_clkB = ~da_clk;
   assign busy = state != IDLE;
   assign strobe = state == RUN && div_cnt == rate_l;
   assign s_ready = (state == PRIME || state == RUN) && (!hold_v || strobe);
   assign xfer = s_valid && s_ready;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = enable ? PRIME : IDLE;
         PRIME: state_nx = !enable ? IDLE : xfer ? RUN : PRIME;
         RUN:   state_nx = enable ? RUN : STOP;
         STOP:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge da_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         rate_l <= '0;
         div_cnt <= '0;
         hold_A <= '0;
         hold_B <= '0;
         hold_v <= 1'b0;
         dac_data_A <= MIDSCALE;
         dac_data_B <= MIDSCALE;
         underflow_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && enable) begin
            rate_l <= rate_div;
            div_cnt <= '0;
            underflow_cnt <= '0;
         end
         if (state == RUN) div_cnt <= strobe ? '0 : div_cnt + 1'b1;
         if (xfer) begin
            hold_A <= s_data_A;
            hold_B <= s_data_B;
         end
         // abandoning a start or stopping discards any pending pair
         if (state == STOP || (state == PRIME && !enable)) hold_v <= 1'b0;
         else if (xfer) hold_v <= 1'b1;
         else if (strobe) hold_v <= 1'b0;
         if (state == IDLE || state == STOP) begin
            dac_data_A <= MIDSCALE;
            dac_data_B <= MIDSCALE;
         end else if (strobe && hold_v) begin
            dac_data_A <= map_code(hold_A);
            dac_data_B <= map_code(hold_B);
         end
         if (strobe && !hold_v && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
      end
   end
endmodule
